mem_bus_arbiter: RTL

//   Shares one single-port memory between the core's instruction-fetch requester (IF) and its load/store requester (D).

---
 rtl/mem_bus_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (D) requesters.
// Fixed priority to D, one access in flight, bus error on a hung memory access.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,

  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,

  output logic                stall
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StBusyIf,
    StBusyD,
    StRespIf,
    StRespD
  } state_e;

  state_e state_q, state_d;

  logic              req_we_q, req_we_d;
  logic [BeW-1:0]    req_be_q, req_be_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;

  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              timeout_hit;

  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_err_q, if_err_d;
  logic              d_err_q, d_err_d;

  // Saturating increment; a zero TIMEOUT leaves the counter parked and never fires.
  always_comb begin
    cnt_inc = cnt_q;
    if ((TIMEOUT != 0) && (cnt_q != TimeoutVal)) begin
      cnt_inc = cnt_q + CntW'(1);
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TimeoutVal);

  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_be_d    = req_be_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    cnt_d       = cnt_q;
    if_rdata_d  = if_rdata_q;
    if_err_d    = if_err_q;
    d_rdata_d   = d_rdata_q;
    d_err_d     = d_err_q;

    unique case (state_q)
      StIdle: begin
        if (d_req) begin
          req_we_d    = d_we;
          // Loads read the full word regardless of the requester's byte enables.
          req_be_d    = d_we ? d_be : {BeW{1'b1}};
          req_addr_d  = d_addr;
          req_wdata_d = d_wdata;
          cnt_d       = '0;
          state_d     = StBusyD;
        end else if (if_req) begin
          req_we_d    = 1'b0;
          req_be_d    = {BeW{1'b1}};
          req_addr_d  = if_addr;
          req_wdata_d = '0;
          cnt_d       = '0;
          state_d     = StBusyIf;
        end
      end

      StBusyIf, StBusyD: begin
        cnt_d = cnt_inc;
        // mem_ack takes precedence over a timeout landing on the same edge.
        if (mem_ack || timeout_hit) begin
          if (state_q == StBusyD) begin
            d_rdata_d = mem_ack ? mem_rdata : '0;
            d_err_d   = ~mem_ack;
            state_d   = StRespD;
          end else begin
            if_rdata_d = mem_ack ? mem_rdata : '0;
            if_err_d   = ~mem_ack;
            state_d    = StRespIf;
          end
        end
      end

      StRespIf, StRespD: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      req_we_q    <= 1'b0;
      req_be_q    <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      cnt_q       <= '0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_be_q    <= req_be_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      cnt_q       <= cnt_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
    end
  end

  assign mem_req   = (state_q == StBusyIf) || (state_q == StBusyD);
  assign mem_we    = req_we_q;
  assign mem_be    = req_be_q;
  assign mem_addr  = req_addr_q;
  assign mem_wdata = req_wdata_q;

  assign if_ack    = (state_q == StRespIf);
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign d_ack     = (state_q == StRespD);
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;

  assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule
